// File: rtl/clip_cmp_sched.sv
// Serialises four drawing-area compares per point onto one shared signed comparator.
// Define CLIP_EARLY_OUT_EN to respond as soon as any compare reports outside.
module clip_cmp_sched #(
  localparam int unsigned W = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_we,
  input  logic [W-1:0] cfg_left,
  input  logic [W-1:0] cfg_right,
  input  logic [W-1:0] cfg_top,
  input  logic [W-1:0] cfg_bottom,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_x,
  input  logic [W-1:0] req0_y,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_x,
  input  logic [W-1:0] req1_y,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [3:0]   rsp_code,
  output logic         rsp_inside,
  output logic [W-1:0] cmp_a,
  output logic [W-1:0] cmp_b,
  output logic         cmp_gt,
  output logic         cmp_lt,
  output logic         cmp_gte,
  output logic         cmp_lte,
  input  logic         cmp_result
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StCmpL = 3'd1;
  localparam logic [2:0] StCmpR = 3'd2;
  localparam logic [2:0] StCmpT = 3'd3;
  localparam logic [2:0] StCmpB = 3'd4;
  localparam logic [2:0] StResp = 3'd5;

`ifdef CLIP_EARLY_OUT_EN
  localparam logic EarlyOut = 1'b1;
`else
  localparam logic EarlyOut = 1'b0;
`endif

  logic [2:0]   state_q, state_d;
  logic         rr_q, rr_d;
  logic         id_q, id_d;
  logic [W-1:0] x_q, x_d, y_q, y_d;
  logic [3:0]   code_q, code_d;
  logic [W-1:0] left_q, right_q, top_q, bottom_q;
  logic [W-1:0] snap_l_q, snap_l_d, snap_r_q, snap_r_d;
  logic [W-1:0] snap_t_q, snap_t_d, snap_b_q, snap_b_d;
  logic         grant0, grant1, idle;

  assign idle   = (state_q == StIdle);
  assign grant0 = req0_valid & (~req1_valid | ~rr_q);
  assign grant1 = req1_valid & (~req0_valid | rr_q);

  assign req0_ready = idle & grant0;
  assign req1_ready = idle & grant1;
  assign rsp_valid  = (state_q == StResp);
  assign rsp_id     = id_q;
  assign rsp_code   = code_q;
  assign rsp_inside = rsp_valid & ~|code_q;

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    id_d     = id_q;
    x_d      = x_q;
    y_d      = y_q;
    code_d   = code_q;
    snap_l_d = snap_l_q;
    snap_r_d = snap_r_q;
    snap_t_d = snap_t_q;
    snap_b_d = snap_b_q;
    case (state_q)
      StIdle: begin
        if (grant0 | grant1) begin
          id_d     = grant1;
          x_d      = grant1 ? req1_x : req0_x;
          y_d      = grant1 ? req1_y : req0_y;
          rr_d     = ~grant1;
          code_d   = 4'b0000;
          // Snapshot uses pre-edge area; a same-cycle cfg_we lands on later points.
          snap_l_d = left_q;
          snap_r_d = right_q;
          snap_t_d = top_q;
          snap_b_d = bottom_q;
          state_d  = StCmpL;
        end
      end
      StCmpL: begin
        code_d[0] = cmp_result;
        state_d   = (EarlyOut && cmp_result) ? StResp : StCmpR;
      end
      StCmpR: begin
        code_d[1] = cmp_result;
        state_d   = (EarlyOut && cmp_result) ? StResp : StCmpT;
      end
      StCmpT: begin
        code_d[2] = cmp_result;
        state_d   = (EarlyOut && cmp_result) ? StResp : StCmpB;
      end
      StCmpB: begin
        code_d[3] = cmp_result;
        state_d   = StResp;
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cmp_a   = '0;
    cmp_b   = '0;
    cmp_gt  = 1'b0;
    cmp_lt  = 1'b0;
    cmp_gte = 1'b0;
    cmp_lte = 1'b0;
    case (state_q)
      StCmpL: begin cmp_a = x_q; cmp_b = snap_l_q; cmp_lt = 1'b1; end
      StCmpR: begin cmp_a = x_q; cmp_b = snap_r_q; cmp_gt = 1'b1; end
      StCmpT: begin cmp_a = y_q; cmp_b = snap_t_q; cmp_lt = 1'b1; end
      StCmpB: begin cmp_a = y_q; cmp_b = snap_b_q; cmp_gt = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left_q   <= '0;
      right_q  <= '0;
      top_q    <= '0;
      bottom_q <= '0;
    end else if (cfg_we) begin
      left_q   <= cfg_left;
      right_q  <= cfg_right;
      top_q    <= cfg_top;
      bottom_q <= cfg_bottom;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      rr_q     <= 1'b0;
      id_q     <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      code_q   <= 4'b0000;
      snap_l_q <= '0;
      snap_r_q <= '0;
      snap_t_q <= '0;
      snap_b_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      id_q     <= id_d;
      x_q      <= x_d;
      y_q      <= y_d;
      code_q   <= code_d;
      snap_l_q <= snap_l_d;
      snap_r_q <= snap_r_d;
      snap_t_q <= snap_t_d;
      snap_b_q <= snap_b_d;
    end
  end

endmodule

// File: tb/tb_clip_cmp_sched.sv
// Randomised self-checking bench for clip_cmp_sched with a behavioural outcode model.
// Honours CLIP_EARLY_OUT_EN to select the expected code/latency rules.
module tb_clip_cmp_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic               cfg_we;
  logic        [10:0] cfg_left, cfg_right, cfg_top, cfg_bottom;
  logic               req0_valid, req0_ready, req1_valid, req1_ready;
  logic        [10:0] req0_x, req0_y, req1_x, req1_y;
  logic               rsp_valid, rsp_ready, rsp_id, rsp_inside;
  logic        [3:0]  rsp_code;
  logic signed [10:0] cmp_a, cmp_b;
  logic               cmp_gt, cmp_lt, cmp_gte, cmp_lte, cmp_result;

  int pass_cnt = 0;
  int total_cnt = 0;
  int a_l = 0, a_r = 0, a_t = 0, a_b = 0;

  clip_cmp_sched dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we),
    .cfg_left(cfg_left), .cfg_right(cfg_right), .cfg_top(cfg_top), .cfg_bottom(cfg_bottom),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_code(rsp_code),
    .rsp_inside(rsp_inside), .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_gt(cmp_gt), .cmp_lt(cmp_lt),
    .cmp_gte(cmp_gte), .cmp_lte(cmp_lte), .cmp_result(cmp_result)
  );

  // External comparator.
  always_comb begin
    cmp_result = 1'b0;
    if (cmp_gt)       cmp_result = cmp_a > cmp_b;
    else if (cmp_lt)  cmp_result = cmp_a < cmp_b;
    else if (cmp_gte) cmp_result = cmp_a >= cmp_b;
    else if (cmp_lte) cmp_result = cmp_a <= cmp_b;
  end

  function automatic logic [3:0] ref_code(input int x, input int y, input int l, input int r,
                                           input int t, input int b);
    logic [3:0] c;
    c = {y > b, y < t, x > r, x < l};
`ifdef CLIP_EARLY_OUT_EN
    if (c[0]) c = 4'b0001;
    else if (c[1]) c = 4'b0010;
    else if (c[2]) c = 4'b0100;
`endif
    return c;
  endfunction

  function automatic int ref_lat(input logic [3:0] c);
`ifdef CLIP_EARLY_OUT_EN
    if (c[0]) return 2;
    if (c[1]) return 3;
    if (c[2]) return 4;
`endif
    return c == 4'b1111 ? 5 : 5;
  endfunction

  function automatic int rnd_coord();
    case ($urandom_range(0, 5))
      0:       return -1024;
      1:       return 1023;
      default: return int'($urandom_range(0, 2047)) - 1024;
    endcase
  endfunction

  task automatic set_area(input int l, input int r, input int t, input int b);
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_left = 11'(l); cfg_right = 11'(r); cfg_top = 11'(t); cfg_bottom = 11'(b);
    @(negedge clk);
    cfg_we = 1'b0;
    a_l = l; a_r = r; a_t = t; a_b = b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    a_l = 0; a_r = 0; a_t = 0; a_b = 0;
  endtask

  // One point through the block; optionally rewrites right bound in the accept cycle.
  task automatic do_point(input int id, input int x, input int y, input string name,
                          input bit cfg_upd, input int new_r);
    logic [3:0] exp;
    int n;
    bit ok;
    exp = ref_code(x, y, a_l, a_r, a_t, a_b);
    @(negedge clk);
    if (id == 0) begin req0_valid = 1'b1; req0_x = 11'(x); req0_y = 11'(y); end
    else begin req1_valid = 1'b1; req1_x = 11'(x); req1_y = 11'(y); end
    #1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if ((id == 0 && req0_ready) || (id == 1 && req1_ready)) begin ok = 1'b1; break; end
      @(negedge clk); #1;
    end
    total_cnt++;
    if (!ok) $display("FAIL %s accept: ready never seen, want 1", name); else pass_cnt++;
    if (cfg_upd) begin cfg_we = 1'b1; cfg_right = 11'(new_r); end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0; cfg_we = 1'b0;
    if (cfg_upd) a_r = new_r;
    ok = 1'b0;
    for (n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1'b1; break; end
    end
    total_cnt++;
    if (!ok || n != ref_lat(exp))
      $display("FAIL %s latency: got %0d want %0d", name, n, ref_lat(exp));
    else pass_cnt++;
    total_cnt++;
    if (rsp_code !== exp) $display("FAIL %s code: got %b want %b", name, rsp_code, exp);
    else pass_cnt++;
    total_cnt++;
    if (rsp_id !== 1'(id) || rsp_inside !== (exp == 4'b0000))
      $display("FAIL %s id/inside: got %b/%b want %0d/%b", name, rsp_id, rsp_inside, id,
               exp == 4'b0000);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #12;
    total_cnt++;
    if (rsp_valid !== 1'b0 || rsp_code !== 4'b0 || rsp_id !== 1'b0 || rsp_inside !== 1'b0)
      $display("FAIL reset rsp: got v=%b c=%b id=%b in=%b want 0/0000/0/0", rsp_valid,
               rsp_code, rsp_id, rsp_inside);
    else pass_cnt++;
    total_cnt++;
    if ({cmp_gt, cmp_lt, cmp_gte, cmp_lte} !== 4'b0 || cmp_a !== 11'sd0 || cmp_b !== 11'sd0)
      $display("FAIL reset cmp: got sel=%b a=%0d b=%0d want 0", {cmp_gt, cmp_lt, cmp_gte,
               cmp_lte}, cmp_a, cmp_b);
    else pass_cnt++;
    total_cnt++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
      $display("FAIL reset rr: got r0=%b r1=%b want 1 0", req0_ready, req1_ready);
    else pass_cnt++;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    set_area(0, 319, 0, 239);
    do_point(0, 100, 100, "centre", 1'b0, 0);
    do_point(1, -5, 300, "corner", 1'b0, 0);
  endtask

  task automatic test_edges();
    do_point(0, 0, 239, "edge_lb", 1'b0, 0);
    do_point(1, 319, 0, "edge_rt", 1'b0, 0);
    do_point(0, 320, -1, "just_out", 1'b0, 0);
    do_point(1, -1024, 1023, "extreme", 1'b0, 0);
    set_area(10, 5, 20, 10);
    do_point(0, 7, 15, "degenerate", 1'b0, 0);
  endtask

  task automatic test_alternate();
    int want, ngrant, nrsp, g;
    int qid[$];
    logic [3:0] qcode[$];
    do_reset();
    set_area(-100, 100, -50, 50);
    @(negedge clk);
    req0_x = 11'(rnd_coord() / 8); req0_y = 11'(rnd_coord() / 8);
    req1_x = 11'(rnd_coord() / 8); req1_y = 11'(rnd_coord() / 8);
    req0_valid = 1'b1; req1_valid = 1'b1;
    want = 0; ngrant = 0; nrsp = 0; g = -1;
    for (int i = 0; i < 80 && nrsp < 4; i++) begin
      if (i > 0) @(negedge clk);
      if (g == 0) begin req0_x = 11'(rnd_coord() / 8); req0_y = 11'(rnd_coord() / 8); end
      if (g == 1) begin req1_x = 11'(rnd_coord() / 8); req1_y = 11'(rnd_coord() / 8); end
      g = -1;
      #1;
      if (rsp_valid) begin
        total_cnt++;
        if (qid.size() == 0 || rsp_id !== 1'(qid[0]) || rsp_code !== qcode[0])
          $display("FAIL alt_rsp%0d: got id=%b code=%b want id=%0d code=%b", nrsp, rsp_id,
                   rsp_code, qid.size() ? qid[0] : -1, qcode.size() ? qcode[0] : 4'bx);
        else pass_cnt++;
        if (qid.size()) begin void'(qid.pop_front()); void'(qcode.pop_front()); end
        nrsp++;
      end else if (req0_ready || req1_ready) begin
        g = req1_ready ? 1 : 0;
        total_cnt++;
        if (g != want || (req0_ready && req1_ready))
          $display("FAIL alt_grant%0d: got %0d want %0d", ngrant, g, want);
        else pass_cnt++;
        qid.push_back(g);
        qcode.push_back(g == 0 ? ref_code($signed(req0_x), $signed(req0_y), a_l, a_r, a_t, a_b)
                               : ref_code($signed(req1_x), $signed(req1_y), a_l, a_r, a_t, a_b));
        want = 1 - want;
        ngrant++;
      end
    end
    total_cnt++;
    if (nrsp < 4) $display("FAIL alt_count: got %0d responses want 4", nrsp); else pass_cnt++;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [3:0] exp;
    bit ok, stable;
    set_area(0, 319, 0, 239);
    exp = ref_code(400, 10, a_l, a_r, a_t, a_b);
    @(negedge clk);
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_x = 11'(400); req0_y = 11'(10);
    #1;
    while (!req0_ready) begin @(negedge clk); #1; end
    @(posedge clk); #1;
    req0_x = 11'(5); req1_valid = 1'b1; req1_x = 11'(-3); req1_y = 11'(3);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1'b1; break; end
    end
    total_cnt++;
    if (!ok) $display("FAIL bp_rsp: rsp_valid got 0 want 1"); else pass_cnt++;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_code !== exp || rsp_id !== 1'b0 || req0_ready !== 1'b0 ||
          req1_ready !== 1'b0) stable = 1'b0;
    end
    total_cnt++;
    if (!stable) $display("FAIL bp_hold: got code=%b rdy=%b%b want %b 00", rsp_code,
                          req0_ready, req1_ready, exp);
    else pass_cnt++;
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    total_cnt++;
    if (rsp_valid !== 1'b0 || req1_ready !== 1'b1 || req0_ready !== 1'b0)
      $display("FAIL bp_next: got v=%b r0=%b r1=%b want 0 0 1", rsp_valid, req0_ready,
               req1_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1'b1; break; end
    end
    total_cnt++;
    if (!ok || rsp_id !== 1'b1 || rsp_code !== ref_code(-3, 3, a_l, a_r, a_t, a_b))
      $display("FAIL bp_second: got id=%b code=%b want 1 %b", rsp_id, rsp_code,
               ref_code(-3, 3, a_l, a_r, a_t, a_b));
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_cfg_snapshot();
    set_area(0, 319, 0, 239);
    do_point(0, 100, 0, "snap_old", 1'b1, 50);
    do_point(0, 100, 0, "snap_new", 1'b0, 0);
  endtask

  task automatic test_reset_mid();
    bit seen;
    set_area(0, 319, 0, 239);
    @(negedge clk);
    req0_valid = 1'b1; req0_x = 11'(100); req0_y = 11'(100);
    #1;
    while (!req0_ready) begin @(negedge clk); #1; end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    total_cnt++;
    if (cmp_lt !== 1'b1 || cmp_a !== 11'sd100 || cmp_b !== 11'sd0)
      $display("FAIL mid_ct: got lt=%b a=%0d b=%0d want 1 100 0", cmp_lt, cmp_a, cmp_b);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({cmp_gt, cmp_lt, cmp_gte, cmp_lte} !== 4'b0 || cmp_a !== 11'sd0 || rsp_valid !== 1'b0 ||
        rsp_code !== 4'b0)
      $display("FAIL mid_rst: got sel=%b a=%0d v=%b c=%b want 0", {cmp_gt, cmp_lt, cmp_gte,
               cmp_lte}, cmp_a, rsp_valid, rsp_code);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    a_l = 0; a_r = 0; a_t = 0; a_b = 0;
    seen = 1'b0;
    repeat (10) begin @(negedge clk); if (rsp_valid) seen = 1'b1; end
    total_cnt++;
    if (seen) $display("FAIL mid_norsp: rsp_valid got 1 want 0"); else pass_cnt++;
  endtask

  task automatic test_random();
    int l, r, t, b, x, y;
    for (int i = 0; i < 40; i++) begin
      if (i % 8 == 0) begin
        l = rnd_coord(); r = rnd_coord(); t = rnd_coord(); b = rnd_coord();
        if ($urandom_range(0, 3) != 0) begin
          if (l > r) begin x = l; l = r; r = x; end
          if (t > b) begin y = t; t = b; b = y; end
        end
        set_area(l, r, t, b);
      end
      case ($urandom_range(0, 3))
        0:       begin x = a_l + int'($urandom_range(0, 2)) - 1; y = a_b; end
        1:       begin x = a_r + int'($urandom_range(0, 2)) - 1; y = a_t; end
        default: begin x = rnd_coord(); y = rnd_coord(); end
      endcase
      if (x > 1023) x = 1023;
      if (x < -1024) x = -1024;
      do_point(int'($urandom_range(0, 1)), x, y, "random", 1'b0, 0);
    end
  endtask

  initial begin
    cfg_we = 1'b0; cfg_left = '0; cfg_right = '0; cfg_top = '0; cfg_bottom = '0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_x = '0; req0_y = '0; req1_x = '0; req1_y = '0;
    rsp_ready = 1'b1;
    test_reset();
    test_basic();
    test_edges();
    test_alternate();
    test_backpressure();
    test_cfg_snapshot();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/clip_cmp_sched.md
Name: clip_cmp_sched

Overview:
- Scheduler that shares one external signed 11-bit comparator (a/b operands, one-hot gt/lt/gte/lte select, result) between two point requesters: vertex setup (req0) and rasterizer (req1).
- For each accepted point (x,y), runs four serialized compares against the drawing-area rectangle.
- Returns a 4-bit clip outcode and an inside flag on a valid/ready response channel.
- Sits in the GPU front end, between the requesters and the clip/scissor comparator.

Parameters:
- W, 11, coordinate width; fixed to match the comparator and not overridable.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  drawing-area write strobe
- cfg_left  in  11  signed left bound, inclusive
- cfg_right  in  11  signed right bound, inclusive
- cfg_top  in  11  signed top bound, inclusive
- cfg_bottom  in  11  signed bottom bound, inclusive
- req0_valid  in  1  requester 0 point valid
- req0_ready  out  1  requester 0 accept
- req0_x  in  11  signed x
- req0_y  in  11  signed y
- req1_valid  in  1  requester 1 point valid
- req1_ready  out  1  requester 1 accept
- req1_x  in  11  signed x
- req1_y  in  11  signed y
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result accept
- rsp_id  out  1  requester index of this result
- rsp_code  out  4  outcode: [0] x<left, [1] x>right, [2] y<top, [3] y>bottom
- rsp_inside  out  1  1 when rsp_code==0
- cmp_a  out  11  comparator operand a
- cmp_b  out  11  comparator operand b
- cmp_gt  out  1  comparator select gt
- cmp_lt  out  1  comparator select lt
- cmp_gte  out  1  comparator select gte
- cmp_lte  out  1  comparator select lte
- cmp_result  in  1  comparator result (combinational from cmp_*)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE; rsp_valid=0; rsp_id=0; rsp_code=0; rsp_inside=0; rr pointer=0 (req0 first); area registers all 0; cmp_a/b=0; all cmp selects=0.
- Area registers: load on any cycle where cfg_we=1. On acceptance, a point snapshots the area registers. A cfg_we in the acceptance cycle or later affects only later points.
- FSM states: IDLE, C_L, C_R, C_T, C_B, RESP.
- IDLE:
  - reqN_ready = (state==IDLE) & grantN.
  - Grant goes to the only valid requester. If both are valid, grant goes to the requester selected by the rr pointer.
  - On accept: latch x, y and id; set rr pointer to the requester not granted; clear the code register; go to C_L.
- Compare steps. Each C_* state is exactly 1 cycle, drives exactly one select bit, and captures cmp_result into its code bit at the clock edge:
  - C_L: a=x, b=left, lt → code[0]
  - C_R: a=x, b=right, gt → code[1]
  - C_T: a=y, b=top, lt → code[2]
  - C_B: a=y, b=bottom, gt → code[3]
- Transitions: C_L → C_R → C_T → C_B → RESP.
- RESP:
  - rsp_valid=1; rsp_code, rsp_id and rsp_inside are held stable.
  - On rsp_ready=1, go to IDLE. No accept occurs in the same cycle.
- Latency: with rsp_ready held at 1, rsp_valid rises 5 cycles after the accept edge. Throughput is 1 point per 6 cycles.
- Outside C_* states: cmp selects all 0 and cmp_a/b=0.
- Bounds are inclusive: x==left or x==right gives 0 in the corresponding code bit.
- Signed arithmetic: -1024 < 1023.
- Degenerate rectangle (left>right or top>bottom): every point reports outside; this needs no special case.
- Backpressure: while in RESP, both readies are 0. Requesters must hold valid and data until accepted.
- Reset asserted mid-operation: in-flight point is discarded; no response is emitted.

Optional Feature:
- Macro: CLIP_EARLY_OUT_EN.
- When defined: after any C_* capture with result 1, go directly to RESP.
  - Unevaluated code bits read 0.
  - rsp_inside=0.
  - Latency drops to 2..5 cycles.
- When undefined: always four compares; full outcode; fixed latency of 5.

Test Plan:
- Area L=0,R=319,T=0,B=239; req0 (100,100), rsp_ready=1 → rsp_valid 5 cycles after accept; code=0000, inside=1, id=0.
- Same area; req1 (-5,300) → code=1001, inside=0, id=1. With CLIP_EARLY_OUT_EN: code=0001, rsp_valid 2 cycles after accept.
- Edges (0,239) and (319,0) → code=0000. Point (320,-1) → code=0110.
- req0 and req1 valid continuously → grants alternate 0,1,0,1 starting with 0 after reset. Each response carries the matching id.
- rsp_ready=0 for 10 cycles → rsp outputs stable and both readies 0. After release, the next accept occurs one cycle after the response handshake.
- cfg_we changes right to 50 in the accept cycle of (100,0) → code[1]=0, because the old snapshot is used. The next point (100,0) → code[1]=1.
- rst_n pulsed low during C_T → outputs return to reset values immediately; no rsp_valid follows.
